// File: rtl/mc_decode.sv
// Multicycle controller: steps each instruction through fetch/decode/execute/memory/writeback
// and drives Moore datapath strobes. State advances every clock; ALUControl and FlagW follow the held Funct.
// No backpressure: MULWAIT stretches execute by MUL_LAT cycles with Busy high.
// Optional feature: define MC_DECODE_MUL_EN to compile in multiply detection, MULWAIT, its counter and Busy.
module mc_decode #(
  parameter int ALUCTRL_W = 4,
  parameter int MUL_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           Sh,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic                 RegW,
  output logic                 MemW,
  output logic                 NextPC,
  output logic                 Branch,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           FlagW,
  output logic                 Undef,
  output logic                 Busy
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_MULWAIT = 4'd8,
    S_ALUWB   = 4'd9,
    S_BRANCH  = 4'd10,
    S_UNDEF   = 4'd11
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;
  localparam logic [3:0] ALU_MOV = 4'b0110;
  localparam logic [3:0] ALU_CMP = 4'b0111;

  // Parameter sanity, evaluated at elaboration only
  if (ALUCTRL_W < 4) begin : g_bad_aluctrl_w
    $error("mc_decode: ALUCTRL_W must be at least 4");
  end
  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
    $error("mc_decode: MUL_LAT must be in 1..15");
  end

  state_t     state, state_nx;
  logic       mul_pat;
  logic       alu_ok;
  logic       is_cmp;
  logic       is_addsub;
  logic [3:0] alu_dec;
  logic [1:0] flag_dec;
  logic [3:0] ctl;

  // Multiply shares the AND encoding and is distinguished by Sh=1001
  assign mul_pat   = (Op == 2'b00) && (Funct[5:1] == 5'b00000) && (Sh == 4'b1001);
  assign is_cmp    = (Funct[4:1] == 4'b1010);
  assign is_addsub = (Funct[4:1] == 4'b0100) || (Funct[4:1] == 4'b0010);

  // Operand-routing selects depend only on the instruction class
  assign ImmSrc = Op;
  assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};

  // ALU operation decode from the held Funct; unknown commands flag alu_ok=0
  always_comb begin
    alu_dec = ALU_ADD;
    alu_ok  = 1'b1;
    case (Funct[4:1])
      4'b0100: alu_dec = ALU_ADD;
      4'b0010: alu_dec = ALU_SUB;
      4'b0000: alu_dec = ALU_AND;
      4'b1100: alu_dec = ALU_ORR;
      4'b0001: alu_dec = ALU_EOR;
      4'b1101: alu_dec = ALU_MOV;
      4'b1010: alu_dec = ALU_CMP;
      default: alu_ok  = 1'b0;
    endcase
`ifdef MC_DECODE_MUL_EN
    if (mul_pat) alu_dec = 4'b0101;
`else
    // Without the multiplier the pattern is just the register AND it overlaps
    if (mul_pat) alu_dec = ALU_AND;
`endif
  end

  // Flag-write enables: CMP always writes both, otherwise the S bit gates them
  always_comb begin
    if (is_cmp) flag_dec = 2'b11;
    else        flag_dec = {Funct[0], Funct[0] & is_addsub};
  end

`ifdef MC_DECODE_MUL_EN
  localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);
  logic [3:0] mul_cnt;

  // Multiply wait counter: loaded on entry to MULWAIT, counts down to the exit
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     mul_cnt <= 4'd0;
    else if (state == S_EXECR && mul_pat)          mul_cnt <= MUL_INIT;
    else if (state == S_MULWAIT && mul_cnt != 4'd0) mul_cnt <= mul_cnt - 4'd1;
  end

  assign Busy = (state == S_MULWAIT);
`else
  assign Busy = 1'b0;
`endif

  // State register; reset aborts any instruction and restarts at FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  // Next-state sequencing
  always_comb begin
    state_nx = S_FETCH;
    case (state)
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   state_nx = S_MEMADR;
          2'b00:   state_nx = Funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_nx = S_BRANCH;
          default: state_nx = S_UNDEF;
        endcase
      end
      S_MEMADR: state_nx = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nx = S_MEMWB;
      S_EXECR: begin
`ifdef MC_DECODE_MUL_EN
        if (mul_pat)     state_nx = S_MULWAIT;
        else if (alu_ok) state_nx = S_ALUWB;
        else             state_nx = S_UNDEF;
`else
        state_nx = alu_ok ? S_ALUWB : S_UNDEF;
`endif
      end
      S_EXECI:  state_nx = alu_ok ? S_ALUWB : S_UNDEF;
      S_MULWAIT: begin
`ifdef MC_DECODE_MUL_EN
        state_nx = (mul_cnt == 4'd0) ? S_ALUWB : S_MULWAIT;
`else
        state_nx = S_ALUWB;
`endif
      end
      default:  state_nx = S_FETCH;
    endcase
  end

  // Moore strobes per state; ALU code and flag enables only in execute states
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    RegW      = 1'b0;
    MemW      = 1'b0;
    NextPC    = 1'b0;
    Branch    = 1'b0;
    Undef     = 1'b0;
    FlagW     = 2'b00;
    ctl       = ALU_ADD;
    case (state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_MEMWB: begin
        RegW      = 1'b1;
        ResultSrc = 2'b01;
        NextPC    = (Rd == 4'hF);
      end
      S_EXECR: begin
        ctl   = alu_dec;
        FlagW = flag_dec;
      end
      S_EXECI: begin
        ALUSrcB = 2'b01;
        ctl     = alu_dec;
        FlagW   = flag_dec;
      end
      S_MULWAIT: ctl = alu_dec;
      S_ALUWB: begin
        RegW   = !is_cmp;
        NextPC = !is_cmp && (Rd == 4'hF);
      end
      S_BRANCH: begin
        Branch    = 1'b1;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
      end
      S_UNDEF:  Undef = 1'b1;
      default:  ;
    endcase
    ALUControl      = '0;
    ALUControl[3:0] = ctl;
  end

endmodule

// File: tb/tb_mc_decode.sv
module tb_mc_decode;
  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] Sh;
  logic       IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic       RegW, MemW, NextPC, Branch;
  logic [3:0] ALUControl;
  logic [1:0] FlagW;
  logic       Undef, Busy;

  mc_decode #(.ALUCTRL_W(4), .MUL_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Sh(Sh),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegW(RegW),
    .MemW(MemW), .NextPC(NextPC), .Branch(Branch), .ALUControl(ALUControl),
    .FlagW(FlagW), .Undef(Undef), .Busy(Busy)
  );

  always #5 clk = ~clk;

  logic [22:0] exp_q[$];
  string       tag_q[$];
  int          total = 0;
  int          bad = 0;
  logic [1:0]  cur_imm = 2'b00;
  logic [1:0]  cur_reg = 2'b00;

  wire [22:0] act = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, RegW, MemW, NextPC,
                     Branch, ALUControl, FlagW, Undef, Busy, ImmSrc, RegSrc};

  function automatic logic [18:0] mk(input logic irw, input logic adr, input logic srca,
                                     input logic [1:0] srcb, input logic [1:0] res,
                                     input logic regw, input logic memw, input logic npc,
                                     input logic br, input logic [3:0] alu,
                                     input logic [1:0] fw, input logic u, input logic b);
    return {irw, adr, srca, srcb, res, regw, memw, npc, br, alu, fw, u, b};
  endfunction

  function automatic logic [18:0] exr(input logic [3:0] alu, input logic [1:0] fw);
    return mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, alu, fw, 0, 0);
  endfunction
  function automatic logic [18:0] exi(input logic [3:0] alu, input logic [1:0] fw);
    return mk(0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, alu, fw, 0, 0);
  endfunction
  function automatic logic [18:0] wb(input logic regw, input logic npc);
    return mk(0, 0, 0, 2'b00, 2'b00, regw, 0, npc, 0, 4'b0000, 2'b00, 0, 0);
  endfunction

  task automatic push(input string tag, input logic [18:0] e);
    tag_q.push_back(tag);
    exp_q.push_back({e, cur_imm, cur_reg});
  endtask

  // One controller cycle: queue its expectation, then move to just after the next edge
  task automatic cyc(input string tag, input logic [18:0] e);
    push(tag, e);
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                      input logic [3:0] sh, input logic [1:0] imm, input logic [1:0] rs);
    Op = op; Funct = fn; Rd = rd; Sh = sh;
    cur_imm = imm; cur_reg = rs;
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [22:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %b want %b", t, act, e);
      end
    end
  end

  initial begin : main
    logic [18:0] F, D, MA, MR, MWR, BR, UD, MW;
    F   = mk(1, 0, 1, 2'b10, 2'b10, 0, 0, 1, 0, 4'b0000, 2'b00, 0, 0);
    D   = mk(0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 4'b0000, 2'b00, 0, 0);
    MA  = mk(0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 4'b0000, 2'b00, 0, 0);
    MR  = mk(0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 4'b0000, 2'b00, 0, 0);
    MWR = mk(0, 1, 0, 2'b00, 2'b00, 0, 1, 0, 0, 4'b0000, 2'b00, 0, 0);
    BR  = mk(0, 0, 0, 2'b01, 2'b10, 0, 0, 0, 1, 4'b0000, 2'b00, 0, 0);
    UD  = mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 4'b0000, 2'b00, 1, 0);
    MW  = mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 4'b0101, 2'b00, 0, 1);

    reset = 1'b1;
    load(2'b00, 6'b000000, 4'd0, 4'd0, 2'b00, 2'b00);
    @(posedge clk);
    #1;
    cyc("rst_init0", F);
    cyc("rst_init1", F);
    reset = 1'b0;

    // STR, interrupted by reset in MEMWR
    load(2'b01, 6'b011000, 4'd2, 4'd0, 2'b01, 2'b10);
    cyc("str_fetch", F);
    cyc("str_dec", D);
    cyc("str_adr", MA);
    push("str_memwr", MWR);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (act !== {F, cur_imm, cur_reg}) begin
      bad++;
      $display("FAIL rst_async: got %b want %b", act, {F, cur_imm, cur_reg});
    end
    @(posedge clk);
    #1;
    cyc("rst_hold0", F);
    cyc("rst_hold1", F);
    reset = 1'b0;

    // LDR Rd=3
    load(2'b01, 6'b011001, 4'd3, 4'd0, 2'b01, 2'b10);
    cyc("ldr_fetch", F);
    cyc("ldr_dec", D);
    cyc("ldr_adr", MA);
    cyc("ldr_rd", MR);
    cyc("ldr_wb", mk(0, 0, 0, 2'b00, 2'b01, 1, 0, 0, 0, 4'b0000, 2'b00, 0, 0));

    // ADDS register, Rd=15
    load(2'b00, 6'b001001, 4'd15, 4'd0, 2'b00, 2'b00);
    cyc("adds_fetch", F);
    cyc("adds_dec", D);
    cyc("adds_ex", exr(4'b0000, 2'b11));
    cyc("adds_wb", wb(1, 1));

    // SUBS register, Rd=5
    load(2'b00, 6'b000101, 4'd5, 4'd0, 2'b00, 2'b00);
    cyc("subs_fetch", F);
    cyc("subs_dec", D);
    cyc("subs_ex", exr(4'b0001, 2'b11));
    cyc("subs_wb", wb(1, 0));

    // ANDS immediate, Rd=6: only NZ written
    load(2'b00, 6'b100001, 4'd6, 4'd0, 2'b00, 2'b00);
    cyc("ands_fetch", F);
    cyc("ands_dec", D);
    cyc("ands_ex", exi(4'b0010, 2'b10));
    cyc("ands_wb", wb(1, 0));

    // ORR register without S, Rd=15
    load(2'b00, 6'b011000, 4'd15, 4'd0, 2'b00, 2'b00);
    cyc("orr_fetch", F);
    cyc("orr_dec", D);
    cyc("orr_ex", exr(4'b0011, 2'b00));
    cyc("orr_wb", wb(1, 1));

    // EOR immediate, Rd=7
    load(2'b00, 6'b100010, 4'd7, 4'd0, 2'b00, 2'b00);
    cyc("eor_fetch", F);
    cyc("eor_dec", D);
    cyc("eor_ex", exi(4'b0100, 2'b00));
    cyc("eor_wb", wb(1, 0));

    // MOVS immediate, Rd=9
    load(2'b00, 6'b111011, 4'd9, 4'd0, 2'b00, 2'b00);
    cyc("movs_fetch", F);
    cyc("movs_dec", D);
    cyc("movs_ex", exi(4'b0110, 2'b10));
    cyc("movs_wb", wb(1, 0));

    // CMP immediate
    load(2'b00, 6'b110101, 4'd0, 4'd0, 2'b00, 2'b00);
    cyc("cmpi_fetch", F);
    cyc("cmpi_dec", D);
    cyc("cmpi_ex", exi(4'b0111, 2'b11));
    cyc("cmpi_wb", wb(0, 0));

    // CMP register with S=0 and Rd=15: flags still written, no write, no PC update
    load(2'b00, 6'b010100, 4'd15, 4'd0, 2'b00, 2'b00);
    cyc("cmpr_fetch", F);
    cyc("cmpr_dec", D);
    cyc("cmpr_ex", exr(4'b0111, 2'b11));
    cyc("cmpr_wb", wb(0, 0));

    // MUL Rd=4
    load(2'b00, 6'b000000, 4'd4, 4'b1001, 2'b00, 2'b00);
    cyc("mul_fetch", F);
    cyc("mul_dec", D);
`ifdef MC_DECODE_MUL_EN
    cyc("mul_ex", exr(4'b0101, 2'b00));
    for (int i = 0; i < LAT; i++) cyc("mul_wait", MW);
`else
    cyc("mul_ex", exr(4'b0010, 2'b00));
`endif
    cyc("mul_wb", wb(1, 0));

    // Branch
    load(2'b10, 6'b100000, 4'd0, 4'd0, 2'b10, 2'b01);
    cyc("b_fetch", F);
    cyc("b_dec", D);
    cyc("b_br", BR);

    // Undefined opcode class
    load(2'b11, 6'b000000, 4'd0, 4'd0, 2'b11, 2'b00);
    cyc("op11_fetch", F);
    cyc("op11_dec", D);
    cyc("op11_undef", UD);

    // Undefined data-processing command
    load(2'b00, 6'b011110, 4'd8, 4'd0, 2'b00, 2'b00);
    cyc("fn15_fetch", F);
    cyc("fn15_dec", D);
    cyc("fn15_ex", exr(4'b0000, 2'b00));
    cyc("fn15_undef", UD);

    // Next instruction fetches normally: ADD immediate Rd=1
    load(2'b00, 6'b101000, 4'd1, 4'd0, 2'b00, 2'b00);
    cyc("addi_fetch", F);
    cyc("addi_dec", D);
    cyc("addi_ex", exi(4'b0000, 2'b00));
    cyc("addi_wb", wb(1, 0));
    cyc("end_fetch", F);

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
